// File: rtl/pmem_wb_buffer_pkg.sv
// Shared types and constants for the physical-memory write-back buffer.
// Lines are 256 bits wide. A buffered line is identified by its address
// bits [31:5], which form the line tag.
package pmem_wb_buffer_pkg;

    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;
    localparam int LTAG_W   = 27;

    // One buffered dirty line.
    typedef struct packed {
        logic [LTAG_W-1:0] tag;
        logic [LINE_W-1:0] data;
    } wb_entry_t;

    // Scheduler states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_ACK   = 2'd3
    } wb_state_t;

    // Rebuild a line-aligned memory address from a line tag.
    function automatic logic [31:0] line_addr(input logic [LTAG_W-1:0] tag);
        return {tag, {OFFSET_W{1'b0}}};
    endfunction

endpackage

// File: rtl/pmem_wb_storage.sv
// Circular FIFO of buffered dirty lines with a fully associative tag match.
// Writes coalesce in place, so at most one valid entry matches a given tag.
// Build option PMEM_WB_FORWARD_EN adds the match_data port, which exposes
// the matching entry's data so the scheduler can forward it to reads.
module pmem_wb_storage
    import pmem_wb_buffer_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LTAG_W-1:0] lookup_tag,
    input  logic              push,
    input  logic              write_hit,
    input  logic [LINE_W-1:0] wdata,
    input  logic              pop,
    output logic              match,
    output wb_entry_t         head_entry,
`ifdef PMEM_WB_FORWARD_EN
    output logic [LINE_W-1:0] match_data,
`endif
    output logic [CNT_W-1:0]  count,
    output logic              full
);

    wb_entry_t        entries [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] match_vec;
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W-1:0] match_idx;

    // Compare the lookup tag against every valid entry.
    always_comb begin
        match_vec = '0;
        for (int i = 0; i < DEPTH; i++) begin
            match_vec[i] = valid[i] && (entries[i].tag == lookup_tag);
        end
    end

    // Encode the single matching entry into an index.
    always_comb begin
        match_idx = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (match_vec[i]) begin
                match_idx = PTR_W'(i);
            end
        end
    end

    assign match      = |match_vec;
    assign full       = (count == CNT_W'(DEPTH));
    assign head_entry = entries[head];
`ifdef PMEM_WB_FORWARD_EN
    assign match_data = entries[match_idx].data;
`endif

    // Line storage: new lines land at the tail, coalescing writes overwrite in place.
    always_ff @(posedge clk) begin
        if (push) begin
            entries[tail] <= '{tag: lookup_tag, data: wdata};
        end else if (write_hit) begin
            entries[match_idx].data <= wdata;
        end
    end

    // Pointers, occupancy and valid bits; push and pop never coincide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            valid <= '0;
        end else begin
            if (push) begin
                valid[tail] <= 1'b1;
                tail        <= tail + PTR_W'(1);
            end
            if (pop) begin
                valid[head] <= 1'b0;
                head        <= head + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/pmem_wb_buffer.sv
// Write-back buffer and scheduler between the cache-line arbiter and
// physical memory. Dirty evictions are absorbed into a small FIFO so read
// misses reach memory first; buffered lines drain whenever no request is
// waiting. Build option PMEM_WB_FORWARD_EN lets reads that hit a buffered
// line return its data directly; without it such reads first drain the
// buffer up to and including the matching line and then read memory.
//
// Upstream handshake: up_read / up_write are held by the requester until
// the one-cycle up_resp pulse. Memory handshake: mem_read / mem_write are
// held by this block until the one-cycle mem_resp pulse.
module pmem_wb_buffer
    import pmem_wb_buffer_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       up_address,
    output logic [LINE_W-1:0] up_rdata,
    input  logic [LINE_W-1:0] up_wdata,
    input  logic              up_read,
    input  logic              up_write,
    output logic              up_resp,
    output logic [31:0]       mem_address,
    input  logic [LINE_W-1:0] mem_rdata,
    output logic [LINE_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic              mem_resp
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    wb_state_t         state;
    logic [LTAG_W-1:0] up_tag;
    logic              match;
    logic              full;
    logic [CNT_W-1:0]  count;
    wb_entry_t         head_entry;
    logic [LINE_W-1:0] rdata_q;
    logic              idle;
    logic              push;
    logic              write_hit;
    logic              pop;
    logic              go_read;
    logic              go_fwd;
    logic              go_drain;
    logic              unused_offset;
`ifdef PMEM_WB_FORWARD_EN
    logic [LINE_W-1:0] match_data;
`endif

    // Byte offset within a line plays no part in buffering.
    assign unused_offset = ^up_address[OFFSET_W-1:0];
    assign up_tag        = up_address[31:OFFSET_W];

    pmem_wb_storage #(
        .DEPTH (DEPTH)
    ) u_storage (
        .clk        (clk),
        .rst        (rst),
        .lookup_tag (up_tag),
        .push       (push),
        .write_hit  (write_hit),
        .wdata      (up_wdata),
        .pop        (pop),
        .match      (match),
        .head_entry (head_entry),
`ifdef PMEM_WB_FORWARD_EN
        .match_data (match_data),
`endif
        .count      (count),
        .full       (full)
    );

    // Decisions taken in IDLE, in priority order: reads, then writes, then drains.
    assign idle      = (state == ST_IDLE);
    assign go_read   = idle && up_read && !match;
    assign write_hit = idle && !up_read && up_write && match;
    assign push      = idle && !up_read && up_write && !match && !full;
`ifdef PMEM_WB_FORWARD_EN
    assign go_fwd    = idle && up_read && match;
    assign go_drain  = idle && !up_read && (up_write ? (!match && full) : (count != '0));
`else
    assign go_fwd    = 1'b0;
    assign go_drain  = idle && (up_read ? match : (up_write ? (!match && full) : (count != '0)));
`endif
    assign pop       = (state == ST_DRAIN) && mem_resp;

    // A memory read completes upstream in the same cycle as mem_resp.
    assign up_resp  = (state == ST_ACK) || ((state == ST_READ) && mem_resp);
    assign up_rdata = (state == ST_READ) ? mem_rdata : rdata_q;

    // Scheduler: sequences memory reads, write-backs and upstream acknowledges.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            mem_read    <= 1'b0;
            mem_write   <= 1'b0;
            mem_address <= '0;
            mem_wdata   <= '0;
            rdata_q     <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (go_read) begin
                        mem_read    <= 1'b1;
                        mem_address <= line_addr(up_tag);
                        state       <= ST_READ;
                    end else if (go_fwd) begin
`ifdef PMEM_WB_FORWARD_EN
                        rdata_q <= match_data;
`endif
                        state   <= ST_ACK;
                    end else if (push || write_hit) begin
                        state <= ST_ACK;
                    end else if (go_drain) begin
                        mem_write   <= 1'b1;
                        mem_address <= line_addr(head_entry.tag);
                        mem_wdata   <= head_entry.data;
                        state       <= ST_DRAIN;
                    end
                end
                ST_READ: begin
                    if (mem_resp) begin
                        mem_read <= 1'b0;
                        rdata_q  <= mem_rdata;
                        state    <= ST_IDLE;
                    end
                end
                ST_DRAIN: begin
                    if (mem_resp) begin
                        mem_write <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
